// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared forwarding codes, stage tracking record and helpers for hazard_ctrl
package hazard_pkg;

    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_E  = 2'd1;
    localparam logic [1:0] FWD_M  = 2'd2;
    localparam logic [1:0] FWD_W  = 2'd3;

    // Tracking widths; hazard_ctrl REG_AW/TW must not exceed these.
    localparam int TRK_AW = 5;
    localparam int TRK_TW = 2;

    localparam logic [TRK_TW-1:0] TUSE_NONE = 2'd3;

    typedef struct packed {
        logic [TRK_AW-1:0] dst;
        logic [TRK_TW-1:0] tnew;
    } stage_trk_t;

    function automatic logic [TRK_TW-1:0] sat_dec(input logic [TRK_TW-1:0] t);
        return (t == '0) ? '0 : t - TRK_TW'(1);
    endfunction

    // The youngest stage writing s decides: forward it if ready, otherwise take nothing.
    function automatic logic [1:0] fwd_pick(input logic [TRK_AW-1:0] s, input logic use_e,
                                            input stage_trk_t e, input stage_trk_t m,
                                            input stage_trk_t w);
        if (s == '0)                 return FWD_RF;
        if (use_e && (e.dst == s))   return (e.tnew == '0) ? FWD_E : FWD_RF;
        if (m.dst == s)              return (m.tnew == '0) ? FWD_M : FWD_RF;
        if (w.dst == s)              return (w.tnew == '0) ? FWD_W : FWD_RF;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_ctrl_md_busy_ctr.sv
// rtl/hazard_ctrl_md_busy_ctr.sv - HI/LO busy down-counter; load beats decrement
module md_busy_ctr #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          busy
);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (cnt_q != '0)
            cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - 5-stage MIPS hazard controller: D stall, D/E forward selects, HI/LO interlock
// HAZARD_FWD_EN selects Tuse/Tnew forwarding; undefined gives a full interlock through W with fwd tied to 0.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW      = TRK_AW,
    parameter int TW          = TRK_TW,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] d_rs,
    input  logic [REG_AW-1:0] d_rt,
    input  logic [TW-1:0]     d_rs_tuse,
    input  logic [TW-1:0]     d_rt_tuse,
    input  logic [REG_AW-1:0] d_dst,
    input  logic [TW-1:0]     d_tnew,
    input  logic              d_md_start,
    input  logic              d_md_is_div,
    input  logic              d_md_use,
    output logic              stall,
    output logic [1:0]        fwd_d_rs,
    output logic [1:0]        fwd_d_rt,
    output logic [1:0]        fwd_e_rs,
    output logic [1:0]        fwd_e_rt,
    output logic              md_busy
);

    localparam int MD_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW     = $clog2(MD_MAX + 1);

    stage_trk_t        e_q, e_d, m_q, m_d, w_q, w_d;
    logic [TRK_AW-1:0] e_rs_q, e_rs_d, e_rt_q, e_rt_d;
    logic              e_md_q, e_md_d;

    logic [TRK_AW-1:0] rs_k, rt_k;
    logic [TRK_TW-1:0] rs_tuse, rt_tuse;
    logic              hz_rs, hz_rt;

    assign rs_k    = TRK_AW'(d_rs);
    assign rt_k    = TRK_AW'(d_rt);
    assign rs_tuse = TRK_TW'(d_rs_tuse);
    assign rt_tuse = TRK_TW'(d_rt_tuse);

`ifdef HAZARD_FWD_EN
    assign hz_rs = (rs_k != '0) && (rs_tuse != TUSE_NONE) &&
                   (((e_q.dst == rs_k) && (rs_tuse < e_q.tnew)) ||
                    ((m_q.dst == rs_k) && (rs_tuse < m_q.tnew)));
    assign hz_rt = (rt_k != '0) && (rt_tuse != TUSE_NONE) &&
                   (((e_q.dst == rt_k) && (rt_tuse < e_q.tnew)) ||
                    ((m_q.dst == rt_k) && (rt_tuse < m_q.tnew)));

    assign fwd_d_rs = fwd_pick(rs_k,   1'b1, e_q, m_q, w_q);
    assign fwd_d_rt = fwd_pick(rt_k,   1'b1, e_q, m_q, w_q);
    assign fwd_e_rs = fwd_pick(e_rs_q, 1'b0, e_q, m_q, w_q);
    assign fwd_e_rt = fwd_pick(e_rt_q, 1'b0, e_q, m_q, w_q);
`else
    logic unused_nofwd;

    assign hz_rs = (rs_k != '0) && ((e_q.dst == rs_k) || (m_q.dst == rs_k) || (w_q.dst == rs_k));
    assign hz_rt = (rt_k != '0) && ((e_q.dst == rt_k) || (m_q.dst == rt_k) || (w_q.dst == rt_k));

    assign fwd_d_rs = FWD_RF;
    assign fwd_d_rt = FWD_RF;
    assign fwd_e_rs = FWD_RF;
    assign fwd_e_rt = FWD_RF;

    assign unused_nofwd = ^{rs_tuse, rt_tuse, w_q.tnew, e_rs_q, e_rt_q};
`endif

    // An md start sitting in E has not yet raised md_busy on every path, so it is checked too.
    assign stall = hz_rs | hz_rt | (d_md_use & (md_busy | e_md_q));

    always_comb begin
        e_d    = '0;
        e_rs_d = '0;
        e_rt_d = '0;
        e_md_d = 1'b0;
        if (!stall) begin
            e_d.dst  = TRK_AW'(d_dst);
            e_d.tnew = TRK_TW'(d_tnew);
            e_rs_d   = rs_k;
            e_rt_d   = rt_k;
            e_md_d   = d_md_start;
        end
        m_d.dst  = e_q.dst;
        m_d.tnew = sat_dec(e_q.tnew);
        w_d.dst  = m_q.dst;
        w_d.tnew = sat_dec(m_q.tnew);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_q    <= '0;
            m_q    <= '0;
            w_q    <= '0;
            e_rs_q <= '0;
            e_rt_q <= '0;
            e_md_q <= 1'b0;
        end else begin
            e_q    <= e_d;
            m_q    <= m_d;
            w_q    <= w_d;
            e_rs_q <= e_rs_d;
            e_rt_q <= e_rt_d;
            e_md_q <= e_md_d;
        end
    end

    md_busy_ctr #(.CW(CW)) u_md_busy_ctr (
        .clk      (clk),
        .reset    (reset),
        .load     (d_md_start & ~stall),
        .load_val (d_md_is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES)),
        .busy     (md_busy)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed and random checks of hazard_ctrl against a cycle-history model
module tb_hazard_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;
    localparam int HN     = 4096;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] d_rs, d_rt, d_dst;
    logic [1:0] d_rs_tuse, d_rt_tuse, d_tnew;
    logic       d_md_start, d_md_is_div, d_md_use;
    logic       stall, md_busy;
    logic [1:0] fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_AW(5), .TW(2), .MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .reset(reset),
        .d_rs(d_rs), .d_rt(d_rt), .d_rs_tuse(d_rs_tuse), .d_rt_tuse(d_rt_tuse),
        .d_dst(d_dst), .d_tnew(d_tnew),
        .d_md_start(d_md_start), .d_md_is_div(d_md_is_div), .d_md_use(d_md_use),
        .stall(stall), .fwd_d_rs(fwd_d_rs), .fwd_d_rt(fwd_d_rt),
        .fwd_e_rs(fwd_e_rs), .fwd_e_rt(fwd_e_rt), .md_busy(md_busy)
    );

    typedef struct {
        int rs, rt, rs_tuse, rt_tuse, dst, tnew;
        bit md_start, md_div, md_use;
    } instr_t;

    // hist[j] = what entered E on the edge closing cycle j; entries before valid_from were wiped by reset.
    instr_t hist [HN];
    int     now, valid_from, md_entry, md_len;
    int     checks, passed, fails;

    function automatic instr_t mk(int dst, int tnew, int rs, int rs_tuse, int rt, int rt_tuse,
                                  bit ms = 0, bit mdv = 0, bit mu = 0);
        instr_t r;
        r.dst = dst; r.tnew = tnew; r.rs = rs; r.rs_tuse = rs_tuse; r.rt = rt; r.rt_tuse = rt_tuse;
        r.md_start = ms; r.md_div = mdv; r.md_use = mu | ms;
        return r;
    endfunction

    function automatic instr_t ent(int k);
        int j = now - 1 - k;
        if (j < valid_from) return mk(0, 0, 0, 3, 0, 3);
        return hist[j];
    endfunction

    function automatic int rem(int k);
        instr_t e = ent(k);
        return (e.tnew > k) ? e.tnew - k : 0;
    endfunction

    function automatic bit hz(int s, int tuse);
        instr_t e;
        if (s == 0) return 1'b0;
`ifdef HAZARD_FWD_EN
        for (int k = 0; k < 2; k++) begin
            e = ent(k);
            if (e.dst == s && tuse < rem(k)) return 1'b1;
        end
`else
        for (int k = 0; k < 3; k++) begin
            e = ent(k);
            if (e.dst == s && tuse >= 0) return 1'b1;
        end
`endif
        return 1'b0;
    endfunction

    function automatic int exp_fwd(int first_k, int s);
`ifdef HAZARD_FWD_EN
        instr_t e;
        if (s != 0)
            for (int k = first_k; k < 3; k++) begin
                e = ent(k);
                if (e.dst == s) return (rem(k) == 0) ? k + 1 : 0;
            end
`else
        if (first_k < 0 || s < 0) return -1;
`endif
        return 0;
    endfunction

    function automatic bit exp_busy();
        return (md_entry >= valid_from) && (now > md_entry) && (now <= md_entry + md_len);
    endfunction

    function automatic instr_t rnd();
        instr_t r;
        r.rs = $urandom_range(0, 3);      r.rt = $urandom_range(0, 3);
        r.rs_tuse = $urandom_range(0, 3); r.rt_tuse = $urandom_range(0, 3);
        r.dst = $urandom_range(0, 3);     r.tnew = $urandom_range(0, 3);
        r.md_start = ($urandom_range(0, 15) == 0);
        r.md_div = $urandom_range(0, 1);
        r.md_use = r.md_start || ($urandom_range(0, 7) == 0);
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d at cycle %0d", tag, obs, exp, now);
        end
    endtask

    // One clock: drive D, check every output against the model, then advance the model.
    task automatic step(input instr_t d, input bit rst, output bit o_stall, output bit o_busy,
                        output bit x_stall);
        instr_t e0 = ent(0);
        bit     xb, xs;
        d_rs = 5'(d.rs); d_rt = 5'(d.rt); d_dst = 5'(d.dst);
        d_rs_tuse = 2'(d.rs_tuse); d_rt_tuse = 2'(d.rt_tuse); d_tnew = 2'(d.tnew);
        d_md_start = d.md_start; d_md_is_div = d.md_div; d_md_use = d.md_use;
        reset = rst;
        #1;
        xb = exp_busy();
        xs = hz(d.rs, d.rs_tuse) || hz(d.rt, d.rt_tuse) || (d.md_use && (xb || e0.md_start));
        check("stall",    32'(stall),    32'(xs));
        check("md_busy",  32'(md_busy),  32'(xb));
        check("fwd_d_rs", 32'(fwd_d_rs), exp_fwd(0, d.rs));
        check("fwd_d_rt", 32'(fwd_d_rt), exp_fwd(0, d.rt));
        check("fwd_e_rs", 32'(fwd_e_rs), exp_fwd(1, e0.rs));
        check("fwd_e_rt", 32'(fwd_e_rt), exp_fwd(1, e0.rt));
        o_stall = stall; o_busy = md_busy; x_stall = xs;
        @(posedge clk);
        if (rst) begin
            valid_from = now + 1;
            md_entry   = -1000;
        end else begin
            hist[now] = xs ? mk(0, 0, 0, 3, 0, 3) : d;
            if (!xs && d.md_start) begin
                md_entry = now;
                md_len   = d.md_div ? DIV_N : MULT_N;
            end
        end
        now++;
        #1;
    endtask

    // Hold an instruction in D until it leaves; report how many stall cycles the DUT showed.
    task automatic issue(input instr_t d, output int n_stall);
        bit os, ob, xs;
        n_stall = 0;
        for (int i = 0; i < 40; i++) begin
            step(d, 1'b0, os, ob, xs);
            if (os) n_stall++;
            if (!xs) return;
        end
        check("issue_bound", 32'(xs), 32'd0);
    endtask

    task automatic flush();
        int n;
        for (int i = 0; i < 3; i++) issue(mk(0, 0, 0, 3, 0, 3), n);
    endtask

    initial begin
        instr_t cur;
        int     n, busy_cnt, stall_cnt;
        bit     os, ob, xs, rst;
        int     exp_ilk;
        checks = 0; passed = 0; fails = 0;
        now = 0; valid_from = 0; md_entry = -1000; md_len = 0;
`ifdef HAZARD_FWD_EN
        exp_ilk = 1;
`else
        exp_ilk = 3;
`endif
        reset = 1'b1;
        d_rs = '0; d_rt = '0; d_dst = '0; d_rs_tuse = 2'd3; d_rt_tuse = 2'd3; d_tnew = '0;
        d_md_start = 1'b0; d_md_is_div = 1'b0; d_md_use = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("rst_stall",    32'(stall),    32'd0);
        check("rst_md_busy",  32'(md_busy),  32'd0);
        check("rst_fwd_d_rs", 32'(fwd_d_rs), 32'd0);
        check("rst_fwd_e_rt", 32'(fwd_e_rt), 32'd0);

        // load-use: lw $8 then addu $9,$8,$8
        issue(mk(8, 2, 0, 3, 0, 3), n);
        issue(mk(9, 1, 8, 1, 8, 1), n);
        check("t1_stalls", 32'(n), 32'(exp_ilk));
        flush();

        // ALU result into a branch compare
        issue(mk(8, 1, 0, 3, 0, 3), n);
        issue(mk(0, 0, 8, 0, 0, 0), n);
        check("t2_stalls", 32'(n), 32'(exp_ilk));
        flush();

        // ori $8, addu $8, sw $8
        issue(mk(8, 1, 0, 3, 0, 3), n);
        issue(mk(8, 1, 9, 1, 10, 1), n);
        issue(mk(0, 0, 11, 1, 8, 2), n);
`ifdef HAZARD_FWD_EN
        check("t3_stalls", 32'(n), 32'd0);
`else
        check("t3_stalls", 32'(n), 32'd3);
`endif
        flush();

        // writer of $0 never hazards
        issue(mk(0, 1, 9, 1, 0, 3), n);
        issue(mk(10, 1, 0, 0, 0, 0), n);
        check("t5_stalls", 32'(n), 32'd0);
        flush();

        // div then mflo, and mult then mflo
        for (int v = 0; v < 2; v++) begin
            issue(mk(0, 0, 8, 1, 9, 1, 1'b1, v == 0, 1'b1), n);
            busy_cnt = 0; stall_cnt = 0;
            for (int i = 0; i < 20; i++) begin
                step(mk(10, 1, 0, 3, 0, 3, 1'b0, 1'b0, 1'b1), 1'b0, os, ob, xs);
                if (ob) busy_cnt++;
                if (os) stall_cnt++;
                if (!xs) break;
            end
            check("md_busy_cycles", 32'(busy_cnt), (v == 0) ? 32'(DIV_N) : 32'(MULT_N));
            check("md_stall_cycles", 32'(stall_cnt), (v == 0) ? 32'(DIV_N) : 32'(MULT_N));
            flush();
        end

        // reset during div busy and a pending load-use stall
        issue(mk(0, 0, 0, 3, 0, 3, 1'b1, 1'b1, 1'b1), n);
        issue(mk(8, 2, 0, 3, 0, 3), n);
        step(mk(9, 1, 8, 0, 0, 3), 1'b1, os, ob, xs);
        step(mk(9, 1, 8, 0, 0, 3), 1'b0, os, ob, xs);
        check("t6_stall", 32'(os), 32'd0);
        check("t6_busy",  32'(ob), 32'd0);

        cur = rnd();
        for (int i = 0; i < 800; i++) begin
            rst = ($urandom_range(0, 39) == 0);
            step(cur, rst, os, ob, xs);
            if (rst || !xs) cur = rnd();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
